// File: rtl/irq_a12_counter.sv
// MMC3-style scanline IRQ counter clocked by filtered PPU A12 rises.
// CPU register writes and save-state access are both taken on synchronized M2 falling edges.
module irq_a12_counter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        map_rst_n,
    input  logic        m2,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic        ppu_a12,
    input  logic        mmc3a,
    input  logic        ss_act,
    input  logic        ss_we,
    input  logic [2:0]  ss_addr,
    output logic        irq,
    output logic [7:0]  ss_dout
);

    localparam int unsigned CW = 8;
    localparam int unsigned LW = 2;
    localparam logic [LW-1:0] FILT_MAX = LW'(FILT_LEN);

    localparam logic [3:0] SEL_LATCH  = 4'b1100;
    localparam logic [3:0] SEL_RELOAD = 4'b1101;
    localparam logic [3:0] SEL_IRQ_DIS = 4'b1110;
    localparam logic [3:0] SEL_IRQ_EN = 4'b1111;

    logic [1:0]    m2_sync;
    logic          m2_d;
    logic [1:0]    a12_sync;
    logic          a12_d;

    logic [CW-1:0] latch,    latch_nx;
    logic [CW-1:0] counter,  counter_nx;
    logic          reload,   reload_nx;
    logic          irq_en,   irq_en_nx;
    logic          irq_pend, irq_pend_nx;
    logic [LW-1:0] lowcnt,   lowcnt_nx;

    logic          m2f;
    logic          a12_rise;
    logic          clk_evt;
    logic          cpu_we;
    logic          ss_wr;
    logic [3:0]    reg_sel;
    logic          unused_addr;

    assign unused_addr = ^cpu_addr[12:1];

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            m2_sync  <= 2'b00;
            m2_d     <= 1'b0;
            a12_sync <= 2'b00;
            a12_d    <= 1'b0;
        end else begin
            m2_sync  <= {m2_sync[0], m2};
            m2_d     <= m2_sync[1];
            a12_sync <= {a12_sync[0], ppu_a12};
            a12_d    <= a12_sync[1];
        end
    end

    assign m2f      = m2_d & ~m2_sync[1];
    assign a12_rise = a12_sync[1] & ~a12_d;
    assign clk_evt  = a12_rise & (lowcnt >= FILT_MAX) & ~ss_act;
    assign cpu_we   = m2f & ~cpu_rw & ~ss_act;
    assign ss_wr    = m2f & ss_act & ss_we;
    assign reg_sel  = {cpu_addr[15:13], cpu_addr[0]};

    // Mapper state register
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            latch    <= '0;
            counter  <= '0;
            reload   <= 1'b0;
            irq_en   <= 1'b0;
            irq_pend <= 1'b0;
            lowcnt   <= '0;
        end else begin
            latch    <= latch_nx;
            counter  <= counter_nx;
            reload   <= reload_nx;
            irq_en   <= irq_en_nx;
            irq_pend <= irq_pend_nx;
            lowcnt   <= lowcnt_nx;
        end
    end

    // Ordering: filter, then clock event, then CPU write, then save-state write
    always_comb begin
        latch_nx    = latch;
        counter_nx  = counter;
        reload_nx   = reload;
        irq_en_nx   = irq_en;
        irq_pend_nx = irq_pend;
        lowcnt_nx   = lowcnt;

        if (a12_sync[1]) begin
            lowcnt_nx = '0;
        end else if (m2f && (lowcnt < FILT_MAX)) begin
            lowcnt_nx = lowcnt + LW'(1);
        end

        if (clk_evt) begin
            if ((counter == '0) || reload) begin
                counter_nx = latch;
                reload_nx  = 1'b0;
            end else begin
                counter_nx = counter - CW'(1);
            end
            // MMC3A refuses to re-fire on a counter that was already parked at zero
            if (irq_en && (counter_nx == '0) &&
                (!mmc3a || (counter != '0) || reload)) begin
                irq_pend_nx = 1'b1;
            end
        end

        if (cpu_we) begin
            case (reg_sel)
                SEL_LATCH:  latch_nx = cpu_dat;
                SEL_RELOAD: begin
                    counter_nx = '0;
                    reload_nx  = 1'b1;
                end
                SEL_IRQ_DIS: begin
                    irq_en_nx   = 1'b0;
                    irq_pend_nx = 1'b0;
                end
                SEL_IRQ_EN: irq_en_nx = 1'b1;
                default: ;
            endcase
        end

        if (ss_wr) begin
            case (ss_addr)
                3'd0: latch_nx = cpu_dat;
                3'd1: counter_nx = cpu_dat;
                3'd2: {lowcnt_nx, reload_nx, irq_en_nx, irq_pend_nx} = cpu_dat[4:0];
                default: ;
            endcase
        end
    end

    assign irq = irq_pend;

    // Save-state readback
    always_comb begin
        ss_dout = 8'hFF;
        case (ss_addr)
            3'd0: ss_dout = latch;
            3'd1: ss_dout = counter;
            3'd2: ss_dout = {3'b000, lowcnt, reload, irq_en, irq_pend};
            default: ss_dout = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_irq_a12_counter.sv
// Scoreboard bench for irq_a12_counter: expectations queued with stimulus, drained against DUT outputs.
module tb_irq_a12_counter;

    logic        clk = 1'b0;
    logic        map_rst_n = 1'b0;
    logic        m2 = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dat = 8'h00;
    logic        ppu_a12 = 1'b0;
    logic        mmc3a = 1'b0;
    logic        ss_act = 1'b0;
    logic        ss_we = 1'b0;
    logic [2:0]  ss_addr = 3'd0;
    logic        irq;
    logic [7:0]  ss_dout;

    localparam logic [3:0] SEL_IRQ = 4'd8;

    int errors = 0;
    int checks = 0;

    string      tag_q[$];
    logic [3:0] sel_q[$];
    logic [7:0] exp_q[$];

    irq_a12_counter #(.FILT_LEN(3)) dut (
        .clk      (clk),
        .map_rst_n(map_rst_n),
        .m2       (m2),
        .cpu_rw   (cpu_rw),
        .cpu_addr (cpu_addr),
        .cpu_dat  (cpu_dat),
        .ppu_a12  (ppu_a12),
        .mmc3a    (mmc3a),
        .ss_act   (ss_act),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .irq      (irq),
        .ss_dout  (ss_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [3:0] sel, input logic [7:0] exp);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
    endtask

    task automatic drain();
        string      t;
        logic [3:0] s;
        logic [7:0] e;
        logic [7:0] got;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            if (s == SEL_IRQ) begin
                got = {7'b0, irq};
            end else begin
                ss_addr = s[2:0];
                #1;
                got = ss_dout;
            end
            check(t, got, e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One CPU bus cycle; the synchronized M2 fall lands inside the low phase
    task automatic bus(input logic rw, input logic [15:0] addr, input logic [7:0] dat);
        @(negedge clk);
        cpu_rw = rw; cpu_addr = addr; cpu_dat = dat; m2 = 1'b1;
        idle(4);
        m2 = 1'b0;
        idle(5);
        cpu_rw = 1'b1;
    endtask

    // Bus write whose M2 fall is synchronized alongside an A12 rise (same clk event)
    task automatic bus_evt(input logic [15:0] addr, input logic [7:0] dat);
        ppu_a12 = 1'b0;
        idle(3);
        repeat (3) bus(1'b1, 16'h0000, 8'h00);
        @(negedge clk);
        cpu_rw = 1'b0; cpu_addr = addr; cpu_dat = dat; m2 = 1'b1;
        idle(4);
        m2 = 1'b0; ppu_a12 = 1'b1;
        idle(5);
        cpu_rw = 1'b1;
    endtask

    task automatic pulse(input int n_low);
        ppu_a12 = 1'b0;
        idle(3);
        repeat (n_low) bus(1'b1, 16'h0000, 8'h00);
        ppu_a12 = 1'b1;
        idle(6);
    endtask

    initial begin
        idle(3);
        map_rst_n = 1'b1;
        idle(2);
        sb_push("rst_latch", 4'd0, 8'h00);
        sb_push("rst_counter", 4'd1, 8'h00);
        sb_push("rst_status", 4'd2, 8'h00);
        sb_push("rst_irq", SEL_IRQ, 8'h00);
        sb_push("rst_idx5", 4'd5, 8'hFF);
        drain();

        // Count 3,2,1,0 with irq on the fourth rise
        bus(1'b0, 16'hC000, 8'h03);
        bus(1'b0, 16'hC001, 8'h00);
        bus(1'b0, 16'hE001, 8'h00);
        sb_push("setup_status", 4'd2, 8'h1E);
        sb_push("setup_latch", 4'd0, 8'h03);
        drain();
        for (int i = 0; i < 4; i++) begin
            pulse(3);
            sb_push($sformatf("seq_cnt%0d", i), 4'd1, 8'(3 - i));
            sb_push($sformatf("seq_irq%0d", i), SEL_IRQ, (i == 3) ? 8'h01 : 8'h00);
            drain();
        end
        bus(1'b0, 16'hE000, 8'h00);
        sb_push("e000_irq", SEL_IRQ, 8'h00);
        sb_push("e000_status", 4'd2, 8'h00);
        drain();

        // Short low periods must not clock the counter
        bus(1'b0, 16'hC000, 8'h05);
        bus(1'b0, 16'hC001, 8'h00);
        pulse(3);
        sb_push("filt_load", 4'd1, 8'h05);
        drain();
        for (int i = 0; i < 3; i++) begin
            pulse(1);
            sb_push($sformatf("filt_cnt%0d", i), 4'd1, 8'h05);
            sb_push($sformatf("filt_irq%0d", i), SEL_IRQ, 8'h00);
            drain();
        end

        // latch=0: MMC3B fires every rise, MMC3A only once per reload
        mmc3a = 1'b0;
        bus(1'b0, 16'hC000, 8'h00);
        bus(1'b0, 16'hC001, 8'h00);
        bus(1'b0, 16'hE001, 8'h00);
        for (int i = 0; i < 3; i++) begin
            pulse(3);
            sb_push($sformatf("b_irq%0d", i), SEL_IRQ, 8'h01);
            sb_push($sformatf("b_cnt%0d", i), 4'd1, 8'h00);
            drain();
            bus(1'b0, 16'hE000, 8'h00);
            bus(1'b0, 16'hE001, 8'h00);
            sb_push($sformatf("b_clr%0d", i), SEL_IRQ, 8'h00);
            drain();
        end
        mmc3a = 1'b1;
        bus(1'b0, 16'hC001, 8'h00);
        for (int i = 0; i < 3; i++) begin
            pulse(3);
            sb_push($sformatf("a_irq%0d", i), SEL_IRQ, (i == 0) ? 8'h01 : 8'h00);
            drain();
            bus(1'b0, 16'hE000, 8'h00);
            bus(1'b0, 16'hE001, 8'h00);
        end

        // E000 coincident with the event reaching zero
        mmc3a = 1'b0;
        bus(1'b0, 16'hC000, 8'h01);
        bus(1'b0, 16'hC001, 8'h00);
        pulse(3);
        sb_push("coin_pre_cnt", 4'd1, 8'h01);
        sb_push("coin_pre_irq", SEL_IRQ, 8'h00);
        drain();
        bus_evt(16'hE000, 8'h00);
        sb_push("coin_e000_irq", SEL_IRQ, 8'h00);
        sb_push("coin_e000_cnt", 4'd1, 8'h00);
        sb_push("coin_e000_status", 4'd2, 8'h00);
        drain();

        // C000 coincident: reload uses old latch; C001 coincident: write wins
        bus(1'b0, 16'hC000, 8'h09);
        bus_evt(16'hC000, 8'h20);
        sb_push("coin_c000_latch", 4'd0, 8'h20);
        sb_push("coin_c000_cnt", 4'd1, 8'h09);
        drain();
        bus_evt(16'hC001, 8'h00);
        sb_push("coin_c001_cnt", 4'd1, 8'h00);
        sb_push("coin_c001_status", 4'd2, 8'h04);
        drain();

        // Save-state write/readback; CPU writes and A12 events blocked
        ss_act = 1'b1;
        ss_we  = 1'b1;
        ss_addr = 3'd0; bus(1'b1, 16'h0000, 8'h55);
        ss_addr = 3'd1; bus(1'b1, 16'h0000, 8'h07);
        ss_addr = 3'd2; bus(1'b1, 16'h0000, 8'h06);
        ss_we = 1'b0;
        sb_push("ss_rd0", 4'd0, 8'h55);
        sb_push("ss_rd1", 4'd1, 8'h07);
        sb_push("ss_rd2", 4'd2, 8'h06);
        drain();
        bus(1'b0, 16'hC000, 8'h11);
        pulse(3);
        sb_push("ss_latch_kept", 4'd0, 8'h55);
        sb_push("ss_cnt_kept", 4'd1, 8'h07);
        sb_push("ss_irq", SEL_IRQ, 8'h00);
        drain();
        ss_act = 1'b0;

        // Reset with irq=1, counter=5
        bus(1'b0, 16'hC000, 8'h00);
        bus(1'b0, 16'hC001, 8'h00);
        pulse(3);
        bus(1'b0, 16'hC000, 8'h05);
        bus(1'b0, 16'hC001, 8'h00);
        pulse(3);
        sb_push("pre_rst_cnt", 4'd1, 8'h05);
        sb_push("pre_rst_irq", SEL_IRQ, 8'h01);
        drain();
        @(negedge clk);
        #2 map_rst_n = 1'b0;
        #1;
        sb_push("rst_async_irq", SEL_IRQ, 8'h00);
        drain();
        idle(2);
        map_rst_n = 1'b1;
        idle(1);
        sb_push("post_rst_latch", 4'd0, 8'h00);
        sb_push("post_rst_cnt", 4'd1, 8'h00);
        sb_push("post_rst_status", 4'd2, 8'h00);
        sb_push("post_rst_irq", SEL_IRQ, 8'h00);
        drain();
        bus(1'b0, 16'hC000, 8'h04);
        pulse(2);
        sb_push("post_rst_short", 4'd1, 8'h00);
        drain();
        pulse(3);
        sb_push("post_rst_full", 4'd1, 8'h04);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
